// File: rtl/led_snake_pkg.sv
// Shared types and helpers for the LED snake chaser: mode/direction encodings
// and the switch-to-length clamp.
package led_snake_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'b00,
        MODE_ROT_R  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Requested block length: switch+1, saturated at the bar length.
    function automatic int unsigned clamp_len(input int unsigned sw, input int unsigned n);
        int unsigned req;
        req = sw + 32'd1;
        return (req < n) ? req : n;
    endfunction

endpackage

// File: rtl/led_snake_gen2_prescaler.sv
// Step prescaler: counts button-high cycles and pulses step on every DIV-th one.
import led_snake_pkg::*;

module led_step_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic step
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;

    // Cycle counter: advances only while button is high, wraps after LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (button) begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign step = button && (cnt_r == LAST);

endmodule

// File: rtl/led_snake_gen2.sv
// LED snake chaser: a lit block of switch-selected length rotates or bounces
// across an N_LED bar. Define LED_SNAKE_WRAP_CNT_EN to add the wrap_cnt output.
import led_snake_pkg::*;

module led_snake_gen2 #(
    parameter int N_LED = 16,
    parameter int LEN_W = 4,
    parameter int DIV   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     button,
    input  logic [LEN_W-1:0]         switch,
    input  logic [1:0]               mode,
    output logic [N_LED-1:0]         led,
    output logic [$clog2(N_LED)-1:0] head
`ifdef LED_SNAKE_WRAP_CNT_EN
    ,
    output logic [7:0]               wrap_cnt
`endif
);

    localparam int HW = $clog2(N_LED);
    localparam int LW = $clog2(N_LED + 1);
    localparam logic [HW-1:0] HMAX = HW'(N_LED - 1);
    localparam logic [LW-1:0] LFULL = LW'(N_LED);

    logic             step_s;
    mode_e            mode_s;
    logic [LW-1:0]    len_s;
    logic [HW-1:0]    len_m1_s;
    logic [HW-1:0]    head_c_s;
    dir_e             dir_c_s;
    logic [HW-1:0]    head_n_s;
    dir_e             dir_n_s;
    logic             wrap_s;
    logic [N_LED-1:0] led_n_s;
    logic [N_LED-1:0] led_rst_s;

    logic [HW-1:0]    head_r;
    dir_e             dir_r;
    logic [N_LED-1:0] led_r;

    led_step_prescaler #(
        .DIV    (DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .step   (step_s)
    );

    // Length clamp, bounce head clamp, then the step action for this edge.
    always_comb begin
        mode_s   = mode_e'(mode);
        len_s    = LW'(clamp_len(32'(switch), N_LED));
        len_m1_s = HW'(len_s - LW'(1));

        if ((mode_s == MODE_BOUNCE) && (head_r < len_m1_s)) begin
            head_c_s = len_m1_s;
            dir_c_s  = DIR_LEFT;
        end else begin
            head_c_s = head_r;
            dir_c_s  = dir_r;
        end

        head_n_s = head_c_s;
        dir_n_s  = dir_c_s;
        wrap_s   = 1'b0;
        if (step_s) begin
            case (mode_s)
                MODE_ROT_L: begin
                    if (head_c_s == HMAX) begin
                        head_n_s = '0;
                        wrap_s   = 1'b1;
                    end else begin
                        head_n_s = head_c_s + HW'(1);
                    end
                end
                MODE_ROT_R: begin
                    if (head_c_s == '0) begin
                        head_n_s = HMAX;
                        wrap_s   = 1'b1;
                    end else begin
                        head_n_s = head_c_s - HW'(1);
                    end
                end
                MODE_BOUNCE: begin
                    // A full-length block has nowhere to move.
                    if (len_s == LFULL) begin
                        head_n_s = HMAX;
                    end else if (dir_c_s == DIR_LEFT) begin
                        if (head_c_s == HMAX) begin
                            head_n_s = HMAX - HW'(1);
                            dir_n_s  = DIR_RIGHT;
                            wrap_s   = 1'b1;
                        end else begin
                            head_n_s = head_c_s + HW'(1);
                        end
                    end else begin
                        if (head_c_s == len_m1_s) begin
                            head_n_s = len_m1_s + HW'(1);
                            dir_n_s  = DIR_LEFT;
                            wrap_s   = 1'b1;
                        end else begin
                            head_n_s = head_c_s - HW'(1);
                        end
                    end
                end
                default: begin
                    head_n_s = head_c_s;
                end
            endcase
        end else begin
            head_n_s = head_c_s;
        end
    end

    // Lay the block at the next head (modular distance below head < L), plus the reset pattern.
    always_comb begin
        led_n_s   = '0;
        led_rst_s = '0;
        for (int i = 0; i < N_LED; i++) begin
            int diff;
            diff = int'(head_n_s) - i;
            if (diff < 0) begin
                diff = diff + N_LED;
            end else begin
                diff = diff;
            end
            led_n_s[i]   = (diff < int'(len_s));
            led_rst_s[i] = (i < int'(len_s));
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r <= len_m1_s;
            dir_r  <= DIR_LEFT;
            led_r  <= led_rst_s;
        end else begin
            head_r <= head_n_s;
            dir_r  <= dir_n_s;
            led_r  <= led_n_s;
        end
    end

    assign led  = led_r;
    assign head = head_r;

`ifdef LED_SNAKE_WRAP_CNT_EN
    logic [7:0] wrap_cnt_r;

    // Counts head wraps and bounce reversals, modulo 256.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_cnt_r <= 8'd0;
        end else if (wrap_s) begin
            wrap_cnt_r <= wrap_cnt_r + 8'd1;
        end else begin
            wrap_cnt_r <= wrap_cnt_r;
        end
    end

    assign wrap_cnt = wrap_cnt_r;
`else
    logic unused_wrap_s;
    assign unused_wrap_s = wrap_s;
`endif

endmodule

// File: tb/tb_led_snake_gen2.sv
// Scoreboard bench for led_snake_gen2: a DIV=1 instance and a DIV=3 instance
// share the same stimulus; expectations are queued and checked by a monitor.
module tb_led_snake_gen2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        button = 1'b0;
    logic [3:0]  switch = 4'd0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] led, led3;
    logic [3:0]  head, head3;
`ifdef LED_SNAKE_WRAP_CNT_EN
    logic [7:0]  wrap_cnt, wrap_cnt3;
`endif

    typedef struct {
        logic [15:0] led;
        logic [3:0]  head;
        bit          c1;
        logic [15:0] led3;
        logic [3:0]  head3;
        bit          c3;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    led_snake_gen2 #(.N_LED(16), .LEN_W(4), .DIV(1)) dut (
        .clk(clk), .rst(rst), .button(button), .switch(switch), .mode(mode),
        .led(led), .head(head)
`ifdef LED_SNAKE_WRAP_CNT_EN
        , .wrap_cnt(wrap_cnt)
`endif
    );

    led_snake_gen2 #(.N_LED(16), .LEN_W(4), .DIV(3)) dut3 (
        .clk(clk), .rst(rst), .button(button), .switch(switch), .mode(mode),
        .led(led3), .head(head3)
`ifdef LED_SNAKE_WRAP_CNT_EN
        , .wrap_cnt(wrap_cnt3)
`endif
    );

    // Monitor: outputs present their new value one edge after each queued stimulus.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.c1) begin
                total++;
                if (led !== e.led || head !== e.head) begin
                    bad++;
                    $display("FAIL %s: got led=%h head=%0d, want led=%h head=%0d",
                             e.name, led, head, e.led, e.head);
                end
            end
            if (e.c3) begin
                total++;
                if (led3 !== e.led3 || head3 !== e.head3) begin
                    bad++;
                    $display("FAIL %s(div3): got led=%h head=%0d, want led=%h head=%0d",
                             e.name, led3, head3, e.led3, e.head3);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic b, input logic [3:0] sw, input logic [1:0] m,
                       input logic [15:0] el, input logic [3:0] eh, input bit c1,
                       input logic [15:0] el3, input logic [3:0] eh3, input bit c3,
                       input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; button = b; switch = sw; mode = m;
        e.led = el; e.head = eh; e.c1 = c1;
        e.led3 = el3; e.head3 = eh3; e.c3 = c3; e.name = nm;
        q.push_back(e);
    endtask

    task automatic st(input logic r, input logic b, input logic [3:0] sw, input logic [1:0] m,
                      input logic [15:0] el, input logic [3:0] eh, input string nm);
        cyc(r, b, sw, m, el, eh, 1'b1, 16'h0, 4'd0, 1'b0, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and rotate-left with L=3.
        st(1, 0, 2, 0, 16'h0007, 4'd2, "reset_L3");
        st(0, 1, 2, 0, 16'h000E, 4'd3, "rotl_1");
        st(0, 1, 2, 0, 16'h001C, 4'd4, "rotl_2");
        st(0, 1, 2, 0, 16'h0038, 4'd5, "rotl_3");
        for (int k = 0; k < 5; k++) st(0, 0, 2, 0, 16'h0038, 4'd5, "hold_btn0");
        // Run to head=15, then wrap to 0.
        for (int h = 6; h <= 15; h++) st(0, 1, 2, 0, 16'h0007 << (h - 2), 4'(h), "rotl_run");
        st(0, 1, 2, 0, 16'hC001, 4'd0, "rotl_wrap");
        st(0, 1, 2, 0, 16'h8003, 4'd1, "rotl_after_wrap");
        // Enter bounce while wrapped: clamp to L-1, moving left.
        st(0, 0, 2, 2, 16'h0007, 4'd2, "bounce_enter_clamp");
        st(0, 1, 2, 2, 16'h000E, 4'd3, "bounce_enter_step");
        // Rotate-right wrap from reset.
        st(1, 0, 2, 1, 16'h0007, 4'd2, "reset_L3_b");
        st(0, 1, 2, 1, 16'h8003, 4'd1, "rotr_wrap");
        // Bounce with L=4 across the bar and back.
        st(1, 0, 3, 2, 16'h000F, 4'd3, "reset_L4");
        for (int h = 4; h <= 15; h++) st(0, 1, 3, 2, 16'h000F << (h - 3), 4'(h), "bounce_up");
        st(0, 1, 3, 2, 16'h7800, 4'd14, "bounce_rev_top");
        for (int h = 13; h >= 3; h--) st(0, 1, 3, 2, 16'h000F << (h - 3), 4'(h), "bounce_down");
        st(0, 1, 3, 2, 16'h001E, 4'd4, "bounce_rev_bottom");
        // Full-length block in bounce never moves.
        for (int k = 0; k < 3; k++) st(0, 1, 15, 2, 16'hFFFF, 4'd15, "bounce_full");
        // Length change re-lays at the current head.
        st(1, 0, 1, 0, 16'h0003, 4'd1, "reset_L2");
        for (int h = 2; h <= 5; h++) st(0, 1, 1, 0, 16'h0003 << (h - 1), 4'(h), "rotl_L2");
        st(0, 0, 4, 0, 16'h003E, 4'd5, "len_grow");
        st(1, 0, 2, 2, 16'h0007, 4'd2, "reset_L3_c");
        st(0, 0, 7, 2, 16'h00FF, 4'd7, "bounce_len_clamp");
        st(0, 1, 7, 0, 16'h01FE, 4'd8, "rotl_L8_1");
        st(0, 1, 7, 0, 16'h03FC, 4'd9, "rotl_L8_2");
        st(1, 1, 0, 0, 16'h0001, 4'd0, "midrun_reset");
        st(0, 1, 0, 0, 16'h0002, 4'd1, "step_L1");
        for (int k = 0; k < 3; k++) st(0, 1, 0, 3, 16'h0002, 4'd1, "freeze");
        // Prescaler pacing: DIV=3 instance steps on every third enabled cycle.
        cyc(1, 0, 0, 0, 16'h0001, 4'd0, 1'b1, 16'h0001, 4'd0, 1'b1, "reset_div");
        for (int k = 1; k <= 9; k++)
            cyc(0, 1, 0, 0, 16'h0001 << k, 4'(k), 1'b1,
                16'h0001 << (k / 3), 4'(k / 3), 1'b1, "div_pace");
        st(0, 0, 0, 0, 16'h0200, 4'd9, "div_hold");

        for (int k = 0; k < 4 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
